// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arbiter_pkg;

    localparam int DATA_W            = 6;
    localparam int DEFAULT_MAX_BURST = 4;
    localparam int DEFAULT_CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    // Round-robin pick: on contention the requester that did not hold the
    // last grant wins; a lone requester always wins; nobody -> idle.
    function automatic state_t arbitrate(input logic v0,
                                         input logic v1,
                                         input logic last_gnt);
        state_t pick;
        if (v0 && v1) begin
            pick = last_gnt ? ST_GNT0 : ST_GNT1;
        end else if (v0) begin
            pick = ST_GNT0;
        end else if (v1) begin
            pick = ST_GNT1;
        end else begin
            pick = ST_IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// The shared 2x1 datapath mux: select=1 forwards i_one, otherwise i_zero.
module mux_arbiter_mux
    import mux_arbiter_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         select,
    input  logic [W-1:0] i_one,
    input  logic [W-1:0] i_zero,
    output logic [W-1:0] mux_o
);

    assign mux_o = select ? i_one : i_zero;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter/sequencer for the shared 6-bit 2x1 mux. Each grant is
// capped at MAX_BURST transfers; release and re-arbitration happen in the
// same cycle so back-to-back grants have no bubble.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              o_ready,
    output logic [1:0]        o_grant,
    output logic              o_busy
);

    // Count value of the final transfer allowed inside one grant.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             xfer;
    logic             new_grant;

    assign xfer = o_valid & o_ready;

    // State register: arbiter state, registered mux select, fairness and burst count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next state: arbitrate from idle, count transfers, release on burst end or valid drop.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        new_grant   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d   = arbitrate(req0_valid, req1_valid, last_gnt_q);
                new_grant = 1'b1;
            end
            ST_GNT0: begin
                if ((xfer && (burst_cnt_q == LAST_CNT)) || !req0_valid) begin
                    state_d   = arbitrate(req0_valid, req1_valid, 1'b0);
                    new_grant = 1'b1;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            ST_GNT1: begin
                if ((xfer && (burst_cnt_q == LAST_CNT)) || !req1_valid) begin
                    state_d   = arbitrate(req0_valid, req1_valid, 1'b1);
                    new_grant = 1'b1;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Any fresh grant (including a re-grant to the same side) restarts the burst.
        if (new_grant) begin
            if (state_d == ST_GNT0) begin
                last_gnt_d  = 1'b0;
                burst_cnt_d = '0;
            end else if (state_d == ST_GNT1) begin
                last_gnt_d  = 1'b1;
                burst_cnt_d = '0;
            end
        end
        sel_d = (state_d == ST_GNT1);
    end

    // Outputs: grant/busy from state; handshakes masked during reset so no word is taken.
    always_comb begin
        o_grant    = {state_q == ST_GNT1, state_q == ST_GNT0};
        o_busy     = |o_grant;
        o_valid    = !rst && (((state_q == ST_GNT0) && req0_valid) ||
                              ((state_q == ST_GNT1) && req1_valid));
        req0_ready = !rst && o_ready && (state_q == ST_GNT0);
        req1_ready = !rst && o_ready && (state_q == ST_GNT1);
    end

    mux_arbiter_mux #(
        .W(DATA_W)
    ) u_mux (
        .select (sel_q),
        .i_one  (req1_data),
        .i_zero (req0_data),
        .mux_o  (o_data)
    );

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: reset, streaming, contention, backpressure,
// early release with mid-burst reset, and single-transfer bursts.
module tb_mux_arbiter;
    import mux_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r0v, r1v, ordy, r0rdy, r1rdy, ov, ob;
    logic [5:0]  r0d, r1d, od;
    logic [1:0]  og;

    logic        b0v, b1v, bordy, b0rdy, b1rdy, bov, bob;
    logic [5:0]  b0d, b1d, bod;
    logic [1:0]  bog;

    int checks = 0;
    int errors = 0;

    mux_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0rdy),
        .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1rdy),
        .o_valid(ov), .o_data(od), .o_ready(ordy),
        .o_grant(og), .o_busy(ob)
    );

    mux_arbiter #(.MAX_BURST(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(b0v), .req0_data(b0d), .req0_ready(b0rdy),
        .req1_valid(b1v), .req1_data(b1d), .req1_ready(b1rdy),
        .o_valid(bov), .o_data(bod), .o_ready(bordy),
        .o_grant(bog), .o_busy(bob)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0v = 1'b0; r1v = 1'b0; ordy = 1'b0;
        b0v = 1'b0; b1v = 1'b0; bordy = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp0, exp1, expg, n0, n1;
        logic acc0, acc1;
        rst = 1'b1;
        r0v = 1'b0; r1v = 1'b0; ordy = 1'b0; r0d = '0; r1d = '0;
        b0v = 1'b0; b1v = 1'b0; bordy = 1'b0; b0d = '0; b1d = '0;

        // 1: reset held two cycles with both requesters valid
        r0v = 1'b1; r1v = 1'b1; r0d = 6'h0A; r1d = 6'h15; ordy = 1'b1;
        step();
        step();
        #1;
        chk("t1_rst_grant", og, 0);
        chk("t1_rst_valid", ov, 0);
        chk("t1_rst_rdy0", r0rdy, 0);
        chk("t1_rst_rdy1", r1rdy, 0);
        chk("t1_rst_busy", ob, 0);
        chk("t1_rst_data", od, 6'h0A);
        rst = 1'b0;
        #1;
        chk("t1_idle_after_release", og, 0);
        step();
        #1;
        chk("t1_first_grant", og, 1);
        chk("t1_first_data", od, 6'h0A);
        chk("t1_first_valid", ov, 1);

        // 2: single requester streams 0x01..0x06
        do_reset();
        r0v = 1'b1; r0d = 6'h01; ordy = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            r0d = 6'(k);
            #1;
            chk("t2_grant", og, 1);
            chk("t2_data", od, k);
            chk("t2_rdy0", r0rdy, 1);
            step();
        end
        r0v = 1'b0;
        #1;
        chk("t2_drop_grant", og, 1);
        chk("t2_drop_valid", ov, 0);
        step();
        #1;
        chk("t2_idle_grant", og, 0);
        chk("t2_idle_busy", ob, 0);

        // 3: contention with MAX_BURST=4
        do_reset();
        r0v = 1'b1; r1v = 1'b1; r0d = 6'h0A; r1d = 6'h15; ordy = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            #1;
            expg = (((i / 4) % 2) == 1) ? 2 : 1;
            chk("t3_grant", og, expg);
            chk("t3_data", od, (expg == 1) ? 6'h0A : 6'h15);
            step();
        end

        // 4: backpressure mid-burst freezes the count
        do_reset();
        r0v = 1'b1; r0d = 6'h21; r1v = 1'b1; r1d = 6'h3F; ordy = 1'b1;
        step();
        #1;
        chk("t4_grant", og, 1);
        chk("t4_data", od, 6'h21);
        step();
        r0d = 6'h22; ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_stall_valid", ov, 1);
            chk("t4_stall_data", od, 6'h22);
            chk("t4_stall_rdy0", r0rdy, 0);
            chk("t4_stall_grant", og, 1);
            step();
        end
        ordy = 1'b1;
        for (int k = 6'h22; k <= 6'h24; k++) begin
            r0d = 6'(k);
            #1;
            chk("t4_resume_grant", og, 1);
            chk("t4_resume_data", od, k);
            chk("t4_resume_rdy0", r0rdy, 1);
            step();
        end
        r0d = 6'h25;
        #1;
        chk("t4_switch_grant", og, 2);
        chk("t4_switch_data", od, 6'h3F);

        // 5: early release by valid drop, then reset mid-burst
        do_reset();
        r1v = 1'b1; r1d = 6'h11; ordy = 1'b1;
        step();
        #1;
        chk("t5_grant1", og, 2);
        chk("t5_data1", od, 6'h11);
        chk("t5_rdy1", r1rdy, 1);
        step();
        r1d = 6'h12;
        #1;
        chk("t5_data2", od, 6'h12);
        step();
        r1v = 1'b0; r0v = 1'b1; r0d = 6'h05;
        #1;
        chk("t5_hold_grant", og, 2);
        chk("t5_hold_valid", ov, 0);
        step();
        #1;
        chk("t5_grant0", og, 1);
        chk("t5_data0", od, 6'h05);
        chk("t5_rdy0", r0rdy, 1);
        step();
        r0d = 6'h06; rst = 1'b1;
        #1;
        chk("t5_rst_cycle_rdy0", r0rdy, 0);
        chk("t5_rst_cycle_valid", ov, 0);
        step();
        rst = 1'b0;
        #1;
        chk("t5_after_rst_grant", og, 0);
        chk("t5_after_rst_busy", ob, 0);
        chk("t5_after_rst_valid", ov, 0);
        chk("t5_after_rst_rdy0", r0rdy, 0);
        chk("t5_after_rst_data", od, 6'h06);

        // 6: MAX_BURST=1, both valid, strict alternation with scoreboard
        do_reset();
        b0v = 1'b1; b1v = 1'b1; b0d = 6'h00; b1d = 6'h20; bordy = 1'b1;
        exp0 = 0; exp1 = 6'h20; expg = 1; n0 = 0; n1 = 0;
        step();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t6_grant", bog, expg);
            chk("t6_rdy0", b0rdy, (expg == 1) ? 1 : 0);
            acc0 = b0rdy;
            acc1 = b1rdy;
            if (acc0) begin
                chk("t6_seq0", bod, exp0);
                exp0++;
                n0++;
            end
            if (acc1) begin
                chk("t6_seq1", bod, exp1);
                exp1++;
                n1++;
            end
            step();
            if (acc0) b0d = b0d + 6'd1;
            if (acc1) b1d = b1d + 6'd1;
            expg = (expg == 1) ? 2 : 1;
        end
        chk("t6_count0", n0, 4);
        chk("t6_count1", n1, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 6-bit 2x1 datapath mux. Two requesters present 6-bit words with valid/ready handshakes. The block drives the mux select, forwards the granted requester's word to a single downstream consumer, and bounds each grant to a configurable burst length so neither requester can starve the other. It sits between the two producers and the consumer of the shared 6-bit path.

Parameters:
MAX_BURST, 4, maximum transfers per grant before forced re-arbitration (legal range 1..15)
CNT_W, 4, burst counter width; must satisfy 2**CNT_W > MAX_BURST

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has a word
req0_data  in  6  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle
req1_valid  in  1  requester 1 has a word
req1_data  in  6  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle
o_valid  out  1  forwarded word valid
o_data  out  6  forwarded word (mux output)
o_ready  in  1  consumer accepts word
o_grant  out  2  one-hot current grant; 2'b00 when idle
o_busy  out  1  a grant is active

Behaviour:
- Reset: clk and rst are decided (one clock; rst synchronous, active-high). Synchronous rst drives state to IDLE, sel=0, burst_cnt=0, last_gnt=1.
  - Resulting outputs: o_grant=00, o_busy=0, o_valid=0, req0_ready=0, req1_ready=0. o_data equals req0_data (sel=0).
  - rst mid-burst abandons the grant. A word presented during the rst cycle is not accepted.
- States:
  - IDLE, GNT0, GNT1; registered sel, last_gnt, burst_cnt.
  - Encodings for these live in the package.
- Outputs (combinational from state):
  - o_grant = {GNT1, GNT0}; o_busy = |o_grant.
  - sel = 1 in GNT1, else 0 (registered, tracks state).
  - o_data = mux(sel, req1_data, req0_data).
  - o_valid = granted requester's valid, 0 in IDLE.
  - reqX_ready = o_ready & GNTX.
- Transfer: xfer = o_valid & o_ready.
- Arbitration decision, used from IDLE and on release:
  - If both request, pick !last_gnt. Otherwise pick the sole requester. None requesting -> IDLE.
  - Entering GNTx sets last_gnt=x and burst_cnt=0.
  - Arbitration latency is 1 cycle: a valid first seen in IDLE is granted the next cycle. No word is accepted in the arbitration cycle.
- In GNTx:
  - Each xfer increments burst_cnt.
  - Release occurs when either condition holds:
    - xfer with burst_cnt == MAX_BURST-1;
    - reqX_valid == 0.
  - On release, the arbitration decision runs in the same cycle with last_gnt = x. The other requester wins if it is valid. Otherwise x is re-granted with a fresh count if still valid, else IDLE.
  - Back-to-back grants take no idle bubble.
  - Otherwise the state is held.
- Handshake rules:
  - Requesters keep valid and data stable until ready. A valid drop is treated as end of stream and releases the grant.
  - o_ready low stalls: no count, no release unless valid drops.
- MAX_BURST=1: every xfer releases. With both requesting, grants strictly alternate 0,1,0,1.
- Counter never exceeds MAX_BURST-1; no wrap-around.
- Simultaneous valid assertion of both from IDLE after reset: requester 0 wins (last_gnt reset value 1).

Decomposition:
- Package mux_arbiter_pkg holds:
  - state typedef/localparams ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2;
  - DATA_W=6;
  - default MAX_BURST.
- One sub-module: instantiate existing mux (select=sel, i_one=req1_data, i_zero=req0_data, mux_o=o_data). The arbiter adds no other datapath.

Test Plan:
1. Reset: assert rst 2 cycles with both valid high -> o_grant=00, o_valid=0, both ready=0. First cycle after rst release: IDLE. Next cycle: o_grant=01, sel=0.
2. Single requester: req0 streams 0x01..0x06, o_ready=1, MAX_BURST=4, req1 idle.
   - Grant to 0 throughout; 6 words out in order.
   - Re-grant to 0 after 4th word with no bubble.
   - Goes IDLE one cycle after valid drops.
3. Contention: both valid continuously (req0 0x0A, req1 0x15), MAX_BURST=4 -> output sequence 4x0x0A, 4x0x15, 4x0x0A, with o_grant switching with no gap.
4. Backpressure: GNT0, o_ready held low 5 cycles mid-burst -> o_data/o_valid stable, burst_cnt frozen, req0_ready=0. Burst completes after o_ready returns.
5. Early release plus reset: req1 granted, drops valid after 2 words while req0 valid -> grant to 0 next cycle. rst asserted mid-burst -> all outputs at reset values next cycle.
6. MAX_BURST=1, both valid -> grants alternate 01,10,01 every transfer; zero words lost or duplicated (scoreboard compares per-requester order).
